// File: rtl/dscope_pkg.sv
// Shared constants and state encoding for the serial DAC receive path.
// The DAC frame layout is MSB first: command field, then the 8-bit level, then don't-care bits.
package dscope_pkg;

    localparam int DAC_FRAME_BITS = 16;
    localparam int DAC_CMD_W      = 4;
    localparam int DAC_DATA_W     = 8;
    localparam logic [3:0] DAC_CMD_WRITE = 4'h3;
    localparam int DAC_LANES      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } dac_rx_state_t;

endpackage

// File: rtl/dac_rx_lane.sv
// One serial lane: shift register, command/level decode and the held level register.
// The level loads only when the shared frame check commits a good frame.
module dac_rx_lane
    import dscope_pkg::*;
#(
    parameter int FRAME_BITS = DAC_FRAME_BITS,
    parameter int CMD_W      = DAC_CMD_W,
    parameter int DATA_W     = DAC_DATA_W,
    parameter logic [CMD_W-1:0] CMD_WRITE = CMD_W'(DAC_CMD_WRITE)
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              d,
    input  logic              commit,
    output logic              is_write,
    output logic [DATA_W-1:0] level
);

    logic [FRAME_BITS-1:0] sr;
    logic [CMD_W-1:0]      cmd;
    logic [DATA_W-1:0]     data;

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[FRAME_BITS-2:0], d};
        end
    end

    assign cmd      = sr[FRAME_BITS-1 -: CMD_W];
    assign data     = sr[FRAME_BITS-1-CMD_W -: DATA_W];
    assign is_write = (cmd == CMD_WRITE);

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (commit && is_write) begin
            level <= data;
        end
    end

endmodule

// File: rtl/dac_serial_rx.sv
// Four-lane cs_n-framed serial receiver: shared frame FSM, bit counter and good-frame counter.
// The frame verdict is registered on the edge that enters CHECK, so results appear two edges after cs_n rises.
module dac_serial_rx
    import dscope_pkg::*;
#(
    parameter int FRAME_BITS = DAC_FRAME_BITS,
    parameter int CMD_W      = DAC_CMD_W,
    parameter int DATA_W     = DAC_DATA_W,
    parameter logic [CMD_W-1:0] CMD_WRITE = CMD_W'(DAC_CMD_WRITE)
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              i_dac_cs_n,
    input  logic              i_dac_data_0,
    input  logic              i_dac_data_1,
    input  logic              i_dac_data_2,
    input  logic              i_dac_data_3,
    output logic [DATA_W-1:0] o_level_0,
    output logic [DATA_W-1:0] o_level_1,
    output logic [DATA_W-1:0] o_level_2,
    output logic [DATA_W-1:0] o_level_3,
    output logic              o_update,
    output logic [3:0]        o_lane_wr,
    output logic              o_frame_err,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt,
    output dac_rx_state_t     dbg_state
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);

    logic                  cs_q;
    logic                  cs_prev;
    logic [3:0]            d_q;
    logic                  cs_fall;
    dac_rx_state_t         state, state_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic                  shift_en;
    logic                  frame_end;
    logic                  frame_good;
    logic                  frame_bad;
    logic [3:0]            lane_is_write;
    logic [DATA_W-1:0]     lane_level [DAC_LANES];
    logic [15:0]           frame_cnt_q;

    // cs_prev resets high so a cs_n held low through reset still reads as a falling edge
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q    <= 1'b1;
            cs_prev <= 1'b1;
            d_q     <= '0;
        end else begin
            cs_q    <= i_dac_cs_n;
            cs_prev <= cs_q;
            d_q     <= {i_dac_data_3, i_dac_data_2, i_dac_data_1, i_dac_data_0};
        end
    end

    assign cs_fall = cs_prev & ~cs_q;

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE, CHECK: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    shift_en  = 1'b1;
                    bit_cnt_d = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cs_q) begin
                    state_d   = CHECK;
                    frame_end = 1'b1;
                end else begin
                    shift_en  = 1'b1;
                    bit_cnt_d = (bit_cnt == CNT_OVR) ? CNT_OVR : bit_cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_good = frame_end && (bit_cnt == CNT_GOOD);
    assign frame_bad  = frame_end && (bit_cnt != CNT_GOOD);

    for (genvar i = 0; i < DAC_LANES; i++) begin : g_lane
        dac_rx_lane #(
            .FRAME_BITS (FRAME_BITS),
            .CMD_W      (CMD_W),
            .DATA_W     (DATA_W),
            .CMD_WRITE  (CMD_WRITE)
        ) u_lane (
            .adc_clk  (adc_clk),
            .rst_n    (rst_n),
            .shift_en (shift_en),
            .d        (d_q[i]),
            .commit   (frame_good),
            .is_write (lane_is_write[i]),
            .level    (lane_level[i])
        );
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_lane_wr   <= '0;
            o_update    <= 1'b0;
            o_frame_err <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            o_lane_wr   <= frame_good ? lane_is_write : 4'b0000;
            o_update    <= frame_good && (|lane_is_write);
            o_frame_err <= frame_bad;
            if (frame_good) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign o_level_0   = lane_level[0];
    assign o_level_1   = lane_level[1];
    assign o_level_2   = lane_level[2];
    assign o_level_3   = lane_level[3];
    assign o_frame_cnt = frame_cnt_q;
    assign o_busy      = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Bench for dac_serial_rx: directed frames plus random frames scored against a frame-level model.
module tb_dac_serial_rx;
    import dscope_pkg::*;

    logic          adc_clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic [3:0]    d;
    logic [7:0]    o_level_0, o_level_1, o_level_2, o_level_3;
    logic          o_update;
    logic [3:0]    o_lane_wr;
    logic          o_frame_err;
    logic          o_busy;
    logic [15:0]   o_frame_cnt;
    dac_rx_state_t dbg_state;

    dac_serial_rx dut (
        .adc_clk      (adc_clk),
        .rst_n        (rst_n),
        .i_dac_cs_n   (cs_n),
        .i_dac_data_0 (d[0]),
        .i_dac_data_1 (d[1]),
        .i_dac_data_2 (d[2]),
        .i_dac_data_3 (d[3]),
        .o_level_0    (o_level_0),
        .o_level_1    (o_level_1),
        .o_level_2    (o_level_2),
        .o_level_3    (o_level_3),
        .o_update     (o_update),
        .o_lane_wr    (o_lane_wr),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 adc_clk = ~adc_clk;
    int unsigned cyc = 0;
    always @(posedge adc_clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // frame-level reference model
    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [3:0]  wr;
        logic [31:0] lv;
        logic [15:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_lv [4];
    logic [15:0] m_cnt;
    logic        mon_en = 1'b0;

    function automatic logic [31:0] model_levels();
        return {m_lv[3], m_lv[2], m_lv[1], m_lv[0]};
    endfunction

    task automatic model_frame(input int nbits, input logic [3:0][15:0] w);
        exp_t e;
        e.due = cyc + 2;
        e.wr  = 4'b0000;
        e.err = (nbits != 16);
        if (nbits == 16) begin
            for (int l = 0; l < 4; l++) begin
                if (w[l][15:12] == 4'h3) begin
                    m_lv[l] = w[l][11:4];
                    e.wr[l] = 1'b1;
                end
            end
            m_cnt = m_cnt + 16'd1;
        end
        e.lv  = model_levels();
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // scoreboard: verdict due at a known cycle, silence everywhere else
    always @(negedge adc_clk) begin
        if (mon_en && rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("update",    64'(o_update),    64'(|e.wr));
                check_val("lane_wr",   64'(o_lane_wr),   64'(e.wr));
                check_val("frame_err", 64'(o_frame_err), 64'(e.err));
                check_val("levels", 64'({o_level_3, o_level_2, o_level_1, o_level_0}), 64'(e.lv));
                check_val("frame_cnt", 64'(o_frame_cnt), 64'(e.cnt));
            end else begin
                check_val("quiet", 64'({o_update, o_frame_err, o_lane_wr}), 64'(0));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic send_frame(input int nbits, input logic [3:0][15:0] w, input int gap);
        for (int b = 0; b < nbits; b++) begin
            cs_n = 1'b0;
            for (int l = 0; l < 4; l++) begin
                d[l] = (b < 16) ? w[l][15-b] : 1'($urandom_range(0, 1));
            end
            if (b == 2) begin
                @(negedge adc_clk);
                check_val("busy_in_frame", 64'(o_busy), 64'(1));
            end
            tick();
        end
        cs_n = 1'b1;
        d    = 4'($urandom_range(0, 15));
        model_frame(nbits, w);
        repeat (gap) tick();
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] c;
        c = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'($urandom_range(0, 15));
        return {c, 12'($urandom_range(0, 4095))};
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [3:0][15:0] w;
        int nb;

        for (int l = 0; l < 4; l++) m_lv[l] = 8'h00;
        m_cnt = 16'h0000;
        cs_n  = 1'b1;
        d     = 4'b0000;
        rst_n = 1'b0;
        repeat (3) tick();

        check_val("rst_levels", 64'({o_level_3, o_level_2, o_level_1, o_level_0}), 64'(0));
        check_val("rst_flags", 64'({o_update, o_frame_err, o_lane_wr, o_busy}), 64'(0));
        check_val("rst_cnt", 64'(o_frame_cnt), 64'(0));
        check_val("rst_state", 64'(dbg_state), 64'(IDLE));

        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();

        // single lane write, others carry cmd 0
        w = {16'h0FFF, 16'h0123, 16'h0ABC, 16'h3A57};
        send_frame(16, w, 4);
        check_val("lane0_level", 64'(o_level_0), 64'(8'hA5));
        check_val("cnt_after_first", 64'(o_frame_cnt), 64'(1));
        check_val("idle_after_frame", 64'(o_busy), 64'(0));

        // all four lanes write
        w = {16'h3440, 16'h3330, 16'h3220, 16'h3110};
        send_frame(16, w, 3);

        // short then overrun frames
        send_frame(15, w, 3);
        send_frame(17, {16'h3999, 16'h3999, 16'h3999, 16'h3999}, 3);
        wait_drain("drain_err");
        check_val("levels_after_err", 64'({o_level_3, o_level_2, o_level_1, o_level_0}), 64'(32'h44332211));

        // back-to-back with 2-cycle and 1-cycle high gaps
        send_frame(16, {16'h3010, 16'h3020, 16'h3030, 16'h3040}, 2);
        send_frame(16, {16'h3500, 16'h0000, 16'h3600, 16'h0000}, 1);
        send_frame(16, {16'h37F0, 16'h38E0, 16'h0000, 16'h39D0}, 1);
        send_frame(16, {16'h1000, 16'h2000, 16'h4000, 16'h5000}, 4);
        wait_drain("drain_b2b");

        // reset in the middle of a frame
        for (int b = 0; b < 8; b++) begin
            cs_n = 1'b0;
            d    = 4'($urandom_range(0, 15));
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) m_lv[l] = 8'h00;
        m_cnt = 16'h0000;
        exp_q.delete();
        check_val("midrst_levels", 64'({o_level_3, o_level_2, o_level_1, o_level_0}), 64'(0));
        check_val("midrst_flags", 64'({o_update, o_frame_err, o_lane_wr, o_busy}), 64'(0));
        check_val("midrst_cnt", 64'(o_frame_cnt), 64'(0));
        cs_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        send_frame(16, {16'h0000, 16'h0000, 16'h3C30, 16'h0000}, 3);
        wait_drain("drain_rst");

        // counter wrap
        #2 force dut.frame_cnt_q = 16'hFFFF;
        #2 release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        tick();
        send_frame(16, {16'h3770, 16'h0000, 16'h0000, 16'h0000}, 3);
        wait_drain("drain_wrap");
        check_val("cnt_wrapped", 64'(o_frame_cnt), 64'(0));

        // random frames
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                6:       nb = 15;
                7:       nb = 17;
                8:       nb = $urandom_range(3, 14);
                9:       nb = $urandom_range(18, 24);
                default: nb = 16;
            endcase
            for (int l = 0; l < 4; l++) w[l] = rand_word();
            send_frame(nb, w, $urandom_range(1, 3));
        end
        wait_drain("drain_rand");
        check_val("final_levels", 64'({o_level_3, o_level_2, o_level_1, o_level_0}), 64'(model_levels()));
        check_val("final_cnt", 64'(o_frame_cnt), 64'(m_cnt));
        check_val("final_idle", 64'(o_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
